dot_map_tracker: RTL and testbench
==================================

Name: dot_map_tracker

Overview:
- Live pellet-map register for the maze.
- Loads a level's start dot pattern from the level pattern source and counts its dots row-by-row.
- Clears dots as Pac-Man eats them, exposes the map and a per-cell query to the renderer, and pulses level_clear when the last dot is eaten.
- Parametrised in grid size; sits between the level pattern source and game-control and draw logic.

Parameters:
- ROWS, 12, grid rows.
- COLS, 12, grid columns.
- ROW_W, $clog2(ROWS), row index width (derived).
- COL_W, $clog2(COLS), column index width (derived).
- CNT_W, $clog2(ROWS*COLS+1), dot counter width (derived).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- load  in  1  start level: sample start_map.
- start_map  in  ROWS*COLS  start pattern. Row 0 occupies the MSBs; column 0 is the MSB of each row word.
- eat_valid  in  1  Pac-Man occupies cell (eat_row, eat_col) this cycle.
- eat_row  in  ROW_W  eat cell row.
- eat_col  in  COL_W  eat cell column.
- query_row  in  ROW_W  render query row.
- query_col  in  COL_W  render query column.
- query_dot  out  1  dot present at query cell (combinational).
- dot_map  out  ROWS*COLS  current map (registered).
- dots_left  out  CNT_W  remaining dots (registered).
- busy  out  1  high while counting.
- dot_eaten  out  1  one-cycle pulse: a dot was removed.
- level_clear  out  1  one-cycle pulse: map became empty.

Behaviour:
- Cell (r,c) maps to bit index (ROWS-1-r)*COLS + (COLS-1-c).
- Reset values: dot_map=0, dots_left=0, busy=0, dot_eaten=0, level_clear=0, state IDLE, row index 0, accumulator 0.
- FSM states: IDLE, COUNT, ACTIVE, CLEAR.
- load, any state, sampled at cycle t:
  - At t+1: dot_map=start_map, dots_left=0, acc=0, row_idx=0, state COUNT, busy=1.
  - Reset has priority over load; load has priority over eat_valid in the same cycle.
- COUNT: each cycle, acc += popcount(row row_idx of dot_map), then row_idx++. Exactly ROWS cycles.
- End of COUNT: on the cycle row ROWS-1 is added (t+ROWS), the next edge (t+ROWS+1) sets dots_left=total and busy=0.
  - total>0: state ACTIVE.
  - total==0: state CLEAR with a one-cycle level_clear pulse.
- load during COUNT restarts the sequence from row 0 with the new pattern.
- eat_valid outside ACTIVE is ignored; no pulses.
- ACTIVE, eat_valid at t:
  - Out-of-range coordinates (row>=ROWS or col>=COLS): ignored.
  - Bit clear: no change, no pulse.
  - Bit set: at t+1 the bit is cleared, dots_left decrements, dot_eaten=1 for one cycle.
  - If dots_left was 1: level_clear=1 at t+1 (same cycle as dot_eaten), state CLEAR.
- dots_left never underflows; it only decrements when a set bit is cleared.
- CLEAR: map and count hold; waits for load; eats ignored.
- query_dot = dot_map bit at (query_row, query_col); 0 for out-of-range coordinates. It reflects the registered map, so an eat at t is visible at t+1.
- Pulses: dot_eaten and level_clear are single-cycle; never asserted on a load or reset cycle.

Decomposition:
- Shared package:
  - state enum {IDLE, COUNT, ACTIVE, CLEAR}.
  - Default grid constants GRID_ROWS=12, GRID_COLS=12.
  - Function cell_index(r,c) implementing the bit-index mapping.
- Sub-module: dot_row_popcount, parametrised on COLS. COLS-bit row in, $clog2(COLS+1)-bit count out. Used in COUNT and unit-tested on its own.

Test Plan:
- Reset, then load with 12x12 map rows 4..7 = 0x0f0, 0x090, 0x090, 0x0f0 (all else 0):
  - busy high for 12 cycles.
  - dots_left=12 at t+13, state ACTIVE, no level_clear.
- Load a map whose rows are all 0x7fe (120 dots):
  - dots_left=120.
  - eat (0,1) -> dot_eaten pulse, dots_left=119, query_dot(0,1)=0 next cycle.
  - Repeat eat (0,1) -> no pulse, dots_left stays 119.
- Map with a single dot at (11,11):
  - After count, dots_left=1.
  - eat (11,11) -> dot_eaten and level_clear both pulse one cycle, dots_left=0, state CLEAR.
  - Later eats produce no pulses.
- All-zero start_map -> after 12 count cycles, level_clear pulses once and dots_left=0.
- Ordering and range checks:
  - load mid-COUNT -> count restarts; final dots_left matches the second pattern.
  - load and eat_valid in the same cycle -> eat ignored.
  - eat (12,3) -> ignored.
- Reset asserted in ACTIVE with dots_left=50 -> next cycle dot_map=0, dots_left=0, IDLE, no pulses. An eat in IDLE is ignored.

Source files
------------

// File: rtl/dot_map_tracker_pkg.sv
// Shared types and helpers for the pellet-map tracker.
// No logic of its own; imported by the tracker and its bench.
package dot_map_tracker_pkg;

   localparam int GRID_ROWS = 12;
   localparam int GRID_COLS = 12;

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      ACTIVE,
      CLEAR
   } state_e;

   // Row 0 sits in the MSBs and column 0 is the MSB of each row word.
   function automatic int unsigned cell_index(input int unsigned r, input int unsigned c,
                                              input int unsigned rows, input int unsigned cols);
      return (rows - 1 - r) * cols + (cols - 1 - c);
   endfunction

endpackage

// File: rtl/dot_map_tracker_row_popcount.sv
// Combinational dot count of one grid row; zero latency, no flow control.
module dot_row_popcount #(
   parameter int COLS = 12,
   parameter int PC_W = $clog2(COLS + 1)
) (
   input  logic [COLS-1:0] row,
   output logic [PC_W-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < COLS; i++) begin
         count = count + PC_W'(row[i]);
      end
   end

endmodule

// File: rtl/dot_map_tracker.sv
// Live pellet map: loads a level pattern, counts it one row per cycle, clears eaten dots.
// Count finishes ROWS+1 cycles after load; eats take effect next cycle; no backpressure.
module dot_map_tracker
   import dot_map_tracker_pkg::*;
#(
   parameter int ROWS  = GRID_ROWS,
   parameter int COLS  = GRID_COLS,
   parameter int ROW_W = $clog2(ROWS),
   parameter int COL_W = $clog2(COLS),
   parameter int CNT_W = $clog2(ROWS * COLS + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [ROWS*COLS-1:0] start_map,
   input  logic                 eat_valid,
   input  logic [ROW_W-1:0]     eat_row,
   input  logic [COL_W-1:0]     eat_col,
   input  logic [ROW_W-1:0]     query_row,
   input  logic [COL_W-1:0]     query_col,
   output logic                 query_dot,
   output logic [ROWS*COLS-1:0] dot_map,
   output logic [CNT_W-1:0]     dots_left,
   output logic                 busy,
   output logic                 dot_eaten,
   output logic                 level_clear
);

   localparam int N    = ROWS * COLS;
   localparam int PC_W = $clog2(COLS + 1);

   state_e           state_q, state_d;
   logic [ROW_W-1:0] row_idx_q, row_idx_d;
   logic [CNT_W-1:0] acc_q, acc_d;
   logic [N-1:0]     dot_map_q, dot_map_d;
   logic [CNT_W-1:0] dots_left_q, dots_left_d;
   logic             busy_q, busy_d;
   logic             dot_eaten_q, dot_eaten_d;
   logic             level_clear_q, level_clear_d;

   logic [COLS-1:0]  row_word;
   logic [PC_W-1:0]  row_cnt;
   logic [CNT_W-1:0] total;
   int unsigned      eat_idx;
   int unsigned      query_idx;
   logic             eat_in_range;
   logic             query_in_range;
   logic             eat_hit;

   dot_row_popcount #(.COLS(COLS), .PC_W(PC_W)) u_row_popcount (
      .row   (row_word),
      .count (row_cnt)
   );

   always_comb begin
      row_word       = COLS'(dot_map_q >> cell_index(32'(row_idx_q), COLS - 1, ROWS, COLS));
      total          = acc_q + CNT_W'(row_cnt);
      eat_in_range   = (32'(eat_row) < ROWS) && (32'(eat_col) < COLS);
      query_in_range = (32'(query_row) < ROWS) && (32'(query_col) < COLS);
      // Indices are only meaningful when in range; the range flags gate every use.
      eat_idx        = cell_index(32'(eat_row), 32'(eat_col), ROWS, COLS);
      query_idx      = cell_index(32'(query_row), 32'(query_col), ROWS, COLS);
      eat_hit        = eat_valid && eat_in_range && 1'(dot_map_q >> eat_idx)
                       && (dots_left_q != '0);
      query_dot      = query_in_range && 1'(dot_map_q >> query_idx);
   end

   always_comb begin
      state_d       = state_q;
      row_idx_d     = row_idx_q;
      acc_d         = acc_q;
      dot_map_d     = dot_map_q;
      dots_left_d   = dots_left_q;
      busy_d        = busy_q;
      dot_eaten_d   = 1'b0;
      level_clear_d = 1'b0;
      if (load) begin
         dot_map_d   = start_map;
         dots_left_d = '0;
         acc_d       = '0;
         row_idx_d   = '0;
         state_d     = COUNT;
         busy_d      = 1'b1;
      end else begin
         case (state_q)
            COUNT: begin
               acc_d     = total;
               row_idx_d = row_idx_q + ROW_W'(1);
               if (32'(row_idx_q) == ROWS - 1) begin
                  row_idx_d   = '0;
                  dots_left_d = total;
                  busy_d      = 1'b0;
                  if (total == '0) begin
                     state_d       = CLEAR;
                     level_clear_d = 1'b1;
                  end else begin
                     state_d = ACTIVE;
                  end
               end
            end
            ACTIVE: begin
               if (eat_hit) begin
                  dot_map_d   = dot_map_q & ~(N'(1) << eat_idx);
                  dots_left_d = dots_left_q - CNT_W'(1);
                  dot_eaten_d = 1'b1;
                  if (dots_left_q == CNT_W'(1)) begin
                     level_clear_d = 1'b1;
                     state_d       = CLEAR;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         row_idx_q     <= '0;
         acc_q         <= '0;
         dot_map_q     <= '0;
         dots_left_q   <= '0;
         busy_q        <= 1'b0;
         dot_eaten_q   <= 1'b0;
         level_clear_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         row_idx_q     <= row_idx_d;
         acc_q         <= acc_d;
         dot_map_q     <= dot_map_d;
         dots_left_q   <= dots_left_d;
         busy_q        <= busy_d;
         dot_eaten_q   <= dot_eaten_d;
         level_clear_q <= level_clear_d;
      end
   end

   assign dot_map     = dot_map_q;
   assign dots_left   = dots_left_q;
   assign busy        = busy_q;
   assign dot_eaten   = dot_eaten_q;
   assign level_clear = level_clear_q;

endmodule

// File: tb/tb_dot_map_tracker.sv
// Randomised and directed bench for dot_map_tracker against a grid-level reference model.
module tb_dot_map_tracker;
   import dot_map_tracker_pkg::*;

   localparam int ROWS  = 12;
   localparam int COLS  = 12;
   localparam int N     = ROWS * COLS;
   localparam int ROW_W = 4;
   localparam int COL_W = 4;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset, load, eat_valid;
   logic [N-1:0]     start_map;
   logic [ROW_W-1:0] eat_row, query_row;
   logic [COL_W-1:0] eat_col, query_col;
   logic             query_dot, busy, dot_eaten, level_clear;
   logic [N-1:0]     dot_map;
   logic [CNT_W-1:0] dots_left;
   logic [COLS-1:0]  pc_row;
   logic [3:0]       pc_cnt;

   dot_map_tracker #(.ROWS(ROWS), .COLS(COLS)) dut (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .start_map   (start_map),
      .eat_valid   (eat_valid),
      .eat_row     (eat_row),
      .eat_col     (eat_col),
      .query_row   (query_row),
      .query_col   (query_col),
      .query_dot   (query_dot),
      .dot_map     (dot_map),
      .dots_left   (dots_left),
      .busy        (busy),
      .dot_eaten   (dot_eaten),
      .level_clear (level_clear)
   );

   dot_row_popcount #(.COLS(COLS)) u_pc (
      .row   (pc_row),
      .count (pc_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a plain grid of dots plus the externally visible status.
   bit     m_map[ROWS][COLS];
   int     m_left  = 0;
   int     m_total = 0;
   int     m_timer = 0;
   state_e m_st    = IDLE;
   bit     m_de    = 1'b0;
   bit     m_lc    = 1'b0;

   task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int bit_pos(input int r, input int c);
      return (ROWS - 1 - r) * COLS + (COLS - 1 - c);
   endfunction

   function automatic logic [N-1:0] model_vec();
      logic [N-1:0] v = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (m_map[r][c]) v = v | (N'(1) << bit_pos(r, c));
      return v;
   endfunction

   function automatic logic [N-1:0] set_row(input logic [N-1:0] m, input int r, input logic [COLS-1:0] w);
      return m | (N'(w) << ((ROWS - 1 - r) * COLS));
   endfunction

   function automatic logic [N-1:0] rnd_map();
      logic [159:0] w = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return N'(w);
   endfunction

   function automatic logic [N-1:0] sparse_map(input int pct);
      logic [N-1:0] v = '0;
      for (int i = 0; i < N; i++)
         if ($urandom_range(0, 99) < pct) v = v | (N'(1) << i);
      return v;
   endfunction

   task automatic model_step(input bit rst, input bit ld, input logic [N-1:0] map,
                             input bit ev, input int er, input int ec);
      m_de = 1'b0;
      m_lc = 1'b0;
      if (rst) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) m_map[r][c] = 1'b0;
         m_left = 0;
         m_st   = IDLE;
      end else if (ld) begin
         m_total = 0;
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
               m_map[r][c] = 1'(map >> bit_pos(r, c));
               m_total += int'(m_map[r][c]);
            end
         m_left  = 0;
         m_st    = COUNT;
         m_timer = ROWS;
      end else if (m_st == COUNT) begin
         if (m_timer == 1) begin
            m_left = m_total;
            if (m_total == 0) begin
               m_st = CLEAR;
               m_lc = 1'b1;
            end else begin
               m_st = ACTIVE;
            end
         end else begin
            m_timer--;
         end
      end else if (m_st == ACTIVE && ev && er < ROWS && ec < COLS) begin
         if (m_map[er][ec]) begin
            m_map[er][ec] = 1'b0;
            m_left--;
            m_de = 1'b1;
            if (m_left == 0) begin
               m_lc = 1'b1;
               m_st = CLEAR;
            end
         end
      end
   endtask

   task automatic step(input bit rst, input bit ld, input logic [N-1:0] map, input bit ev,
                       input int er, input int ec, input int qr, input int qc);
      bit qexp;
      reset     = rst;
      load      = ld;
      start_map = map;
      eat_valid = ev;
      eat_row   = ROW_W'(er);
      eat_col   = COL_W'(ec);
      query_row = ROW_W'(qr);
      query_col = COL_W'(qc);
      @(posedge clk);
      model_step(rst, ld, map, ev, er, ec);
      #1;
      qexp = 1'b0;
      if (qr < ROWS && qc < COLS) qexp = m_map[qr][qc];
      check("dot_map",     dot_map,          model_vec());
      check("dots_left",   N'(dots_left),    N'(m_left));
      check("busy",        N'(busy),         N'(m_st == COUNT));
      check("dot_eaten",   N'(dot_eaten),    N'(m_de));
      check("level_clear", N'(level_clear),  N'(m_lc));
      check("query_dot",   N'(query_dot),    N'(qexp));
      check("state",       N'(dut.state_q),  N'(m_st));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b0, rnd_map(), 1'b0, 0, 0,
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
   endtask

   task automatic do_load(input logic [N-1:0] m);
      step(1'b0, 1'b1, m, 1'b0, 0, 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
   endtask

   task automatic eat(input int er, input int ec);
      step(1'b0, 1'b0, rnd_map(), 1'b1, er, ec, er, ec);
   endtask

   // Prefer cells that still hold a dot so random runs actually drain levels.
   task automatic eat_targeted();
      int start = int'($urandom_range(0, N - 1));
      int er = int'($urandom_range(0, ROWS - 1));
      int ec = int'($urandom_range(0, COLS - 1));
      for (int k = 0; k < N; k++) begin
         int idx = (start + k) % N;
         if (m_map[idx / COLS][idx % COLS]) begin
            er = idx / COLS;
            ec = idx % COLS;
            break;
         end
      end
      eat(er, ec);
   endtask

   initial begin
      logic [N-1:0] ma, mb, mc, m50;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) m_map[r][c] = 1'b0;

      step(1'b1, 1'b0, rnd_map(), 1'b0, 0, 0, 0, 0);
      step(1'b1, 1'b1, rnd_map(), 1'b1, 0, 0, 0, 0);
      check("rst_map", dot_map, '0);

      ma = '0;
      ma = set_row(ma, 4, 12'h0f0);
      ma = set_row(ma, 5, 12'h090);
      ma = set_row(ma, 6, 12'h090);
      ma = set_row(ma, 7, 12'h0f0);
      do_load(ma);
      idle(11);
      check("a_busy_last", N'(busy), N'(1));
      idle(1);
      check("a_total", N'(dots_left), N'(12));
      check("a_state", N'(dut.state_q), N'(ACTIVE));
      check("a_no_clear", N'(level_clear), N'(0));

      mb = '0;
      for (int r = 0; r < ROWS; r++) mb = set_row(mb, r, 12'h7fe);
      do_load(mb);
      idle(12);
      check("b_total", N'(dots_left), N'(120));
      eat(0, 1);
      check("b_eaten", N'(dot_eaten), N'(1));
      check("b_left", N'(dots_left), N'(119));
      check("b_query", N'(query_dot), N'(0));
      eat(0, 1);
      check("b_reeat", N'(dot_eaten), N'(0));
      check("b_left2", N'(dots_left), N'(119));

      mc = set_row('0, 11, 12'h001);
      do_load(mc);
      idle(12);
      check("c_total", N'(dots_left), N'(1));
      eat(11, 11);
      check("c_eaten", N'(dot_eaten), N'(1));
      check("c_clear", N'(level_clear), N'(1));
      check("c_left", N'(dots_left), N'(0));
      check("c_state", N'(dut.state_q), N'(CLEAR));
      idle(1);
      eat(11, 11);
      eat(3, 3);
      check("c_late_eat", N'(dot_eaten), N'(0));

      do_load('0);
      idle(12);
      check("z_clear", N'(level_clear), N'(1));
      check("z_left", N'(dots_left), N'(0));
      idle(1);
      check("z_pulse_end", N'(level_clear), N'(0));

      do_load(mb);
      idle(5);
      do_load(ma);
      idle(12);
      check("restart_total", N'(dots_left), N'(12));

      step(1'b0, 1'b1, mb, 1'b1, 4, 4, 4, 4);
      idle(12);
      check("ld_eat_total", N'(dots_left), N'(120));
      eat(12, 3);
      check("oor_left", N'(dots_left), N'(120));
      check("oor_eaten", N'(dot_eaten), N'(0));

      m50 = (N'(1) << 50) - N'(1);
      do_load(m50);
      idle(12);
      check("r_total", N'(dots_left), N'(50));
      step(1'b1, 1'b0, rnd_map(), 1'b1, 11, 11, 11, 11);
      check("r_map", dot_map, '0);
      check("r_left", N'(dots_left), N'(0));
      check("r_state", N'(dut.state_q), N'(IDLE));
      eat(11, 11);
      check("idle_eat", N'(dot_eaten), N'(0));

      for (int i = 0; i < 20; i++) begin
         pc_row = COLS'($urandom);
         #1;
         check("popcount", N'(pc_cnt), N'($countones(pc_row)));
      end

      for (int ep = 0; ep < 250; ep++) begin
         do_load(sparse_map(int'($urandom_range(0, 6))));
         for (int k = 0; k < 45; k++) begin
            int p = int'($urandom_range(0, 99));
            if (p < 2)
               step(1'b1, 1'b0, rnd_map(), 1'b1, int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)));
            else if (p < 5)
               step(1'b0, 1'b1, sparse_map(int'($urandom_range(0, 10))), p[0],
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            else if (p < 70)
               eat_targeted();
            else if (p < 85)
               eat(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            else
               idle(1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
